// File: rtl/alu_pkg.sv
// Shared opcode and output-select definitions for the ALU issue stage and datapath.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_SRA     = 3'b010,
        OP_SRL     = 3'b011,
        OP_SLL     = 3'b100,
        OP_AND     = 3'b101,
        OP_OR      = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        OSEL_ADDER = 2'b00,
        OSEL_SHIFT = 2'b01,
        OSEL_LOGIC = 2'b10
    } osel_e;

    function automatic logic is_illegal(input logic [2:0] op);
        return op == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Command-in and result-out handshakes of the ALU issue stage.
interface alu_issue_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_op;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_op, out_err
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO; occupancy counter alone decides full/empty.
module alu_cmd_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    // Zero head when empty so the ALU never sees stale or X operands.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: buffers commands, feeds the head to the external ALU and
// registers its result in a single output slot.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_issue_if.slave             io,
    output logic [2:0]             op,
    output logic [WIDTH-1:0]       a,
    output logic [WIDTH-1:0]       b,
    input  logic [WIDTH-1:0]       alu_result,
    output logic [$clog2(DEPTH):0] count
);
    localparam int FW = 3 + 2 * WIDTH;

    logic             full, empty, push, pop;
    logic [FW-1:0]    head;
    logic             out_valid_q, out_err_q;
    logic [WIDTH-1:0] out_result_q;
    logic [2:0]       out_op_q;

    // in_ready depends on occupancy only, never on out_ready.
    assign io.in_ready = ~full;
    assign push        = io.in_valid & ~full;
    assign pop         = ~empty & (~out_valid_q | io.out_ready);
    assign {op, a, b}  = head;

    alu_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({io.in_op, io.in_a, io.in_b}),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= 3'b000;
            out_err_q    <= 1'b0;
        end else if (pop) begin
            out_valid_q  <= 1'b1;
            out_op_q     <= op;
            out_err_q    <= is_illegal(op);
            out_result_q <= is_illegal(op) ? '0 : alu_result;
        end else if (out_valid_q && io.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_result = out_result_q;
    assign io.out_op     = out_op_q;
    assign io.out_err    = out_err_q;
endmodule
